pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle PC update sequencer. Walks an accepted
// instruction through fetch/decode/resolve, handles invalid-opcode and
// overflow exceptions through an EPC save and an exception-vector read,
// and halts permanently (until reset) if that read never completes.
module pc_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        overflow,
    input  logic        mem_ready,
    output logic        ready,
    output logic [2:0]  PCSource,
    output logic        PCWrite,
    output logic        EPCWrite,
    output logic        exc_cause,
    output logic        exc_mem_rd,
    output logic        done,
    output logic        halted,
    output logic [15:0] taken_cnt
);

    typedef enum logic [3:0] {
        IDLE,
        FETCH_INC,
        DECODE,
        RESOLVE,
        EXC_EPC,
        EXC_RD,
        EXC_LOAD,
        DONE,
        HALT
    } state_t;

    localparam logic [2:0] SRC_PC4  = 3'd0;
    localparam logic [2:0] SRC_BR   = 3'd1;
    localparam logic [2:0] SRC_JMP  = 3'd3;
    localparam logic [2:0] SRC_REGA = 3'd4;
    localparam logic [2:0] SRC_EXC  = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Last counter value before the vector read is declared lost.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [5:0]  opcode_q, opcode_d;
    logic [5:0]  funct_q, funct_d;
    logic        exc_cause_q, exc_cause_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic [15:0] taken_cnt_q, taken_cnt_d;
    logic        opcode_legal;

    assign exc_cause = exc_cause_q;
    assign taken_cnt = taken_cnt_q;

    // Decode of the supported opcode set from the captured instruction.
    always_comb begin
        opcode_legal = opcode_q inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                                        6'h08, 6'h09, 6'h0A, 6'h0F, 6'h20,
                                        6'h23, 6'h28, 6'h2B};
    end

    // Next-state, captured fields, counters and state-decoded outputs.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        funct_d     = funct_q;
        exc_cause_d = exc_cause_q;
        tmo_cnt_d   = tmo_cnt_q;
        taken_cnt_d = taken_cnt_q;
        ready       = 1'b0;
        PCSource    = SRC_PC4;
        PCWrite     = 1'b0;
        EPCWrite    = 1'b0;
        exc_mem_rd  = 1'b0;
        done        = 1'b0;
        halted      = 1'b0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (instr_valid) begin
                    opcode_d = opcode;
                    funct_d  = funct;
                    state_d  = FETCH_INC;
                end
            end
            FETCH_INC: begin
                PCSource = SRC_PC4;
                PCWrite  = 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                if (!opcode_legal) begin
                    exc_cause_d = 1'b0;
                    state_d     = EXC_EPC;
                end else begin
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                state_d = DONE;
                case (opcode_q)
                    OP_BEQ: begin
                        PCSource = SRC_BR;
                        PCWrite  = zero;
                    end
                    OP_BNE: begin
                        PCSource = SRC_BR;
                        PCWrite  = !zero;
                    end
                    OP_J, OP_JAL: begin
                        PCSource = SRC_JMP;
                        PCWrite  = 1'b1;
                    end
                    OP_RTYPE: begin
                        if (funct_q == FN_JR) begin
                            PCSource = SRC_REGA;
                            PCWrite  = 1'b1;
                        end else if (overflow) begin
                            exc_cause_d = 1'b1;
                            state_d     = EXC_EPC;
                        end
                    end
                    OP_ADDI: begin
                        if (overflow) begin
                            exc_cause_d = 1'b1;
                            state_d     = EXC_EPC;
                        end
                    end
                    default: ;
                endcase
                if (PCWrite && (taken_cnt_q != 16'hFFFF)) begin
                    taken_cnt_d = taken_cnt_q + 16'd1;
                end
            end
            EXC_EPC: begin
                EPCWrite  = 1'b1;
                tmo_cnt_d = '0;
                state_d   = EXC_RD;
            end
            EXC_RD: begin
                exc_mem_rd = 1'b1;
                // mem_ready is checked first so it wins on the final cycle.
                if (mem_ready) begin
                    state_d = EXC_LOAD;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = HALT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            EXC_LOAD: begin
                PCSource = SRC_EXC;
                PCWrite  = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            opcode_q    <= '0;
            funct_q     <= '0;
            exc_cause_q <= 1'b0;
            tmo_cnt_q   <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            funct_q     <= funct_d;
            exc_cause_q <= exc_cause_d;
            tmo_cnt_q   <= tmo_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a table of single instructions checked
// cycle by cycle, plus hand sequences for timeout, races and saturation.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, instr_valid, zero, overflow, mem_ready;
    logic [5:0]  opcode, funct;
    logic        ready, PCWrite, EPCWrite, exc_cause, exc_mem_rd, done, halted;
    logic [2:0]  PCSource;
    logic [15:0] taken_cnt;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [15:0] exp_taken = '0;
    logic        exp_cause = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid),
        .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
        .mem_ready(mem_ready), .ready(ready), .PCSource(PCSource),
        .PCWrite(PCWrite), .EPCWrite(EPCWrite), .exc_cause(exc_cause),
        .exc_mem_rd(exc_mem_rd), .done(done), .halted(halted),
        .taken_cnt(taken_cnt)
    );

    // exc: 0 = none, 1 = invalid opcode at decode, 2 = overflow at resolve
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       ov;
        logic [2:0] src;
        logic       wr;
        int         exc;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From first EXC_RD cycle: vector read completes on its first cycle.
    task automatic exc_tail();
        tick();
        chk("exc_rd_req", 32'(exc_mem_rd), 1);
        chk("exc_rd_epc", 32'(EPCWrite), 0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("exc_load_src", 32'(PCSource), 5);
        chk("exc_load_wr", 32'(PCWrite), 1);
        chk("exc_load_rd", 32'(exc_mem_rd), 0);
        tick();
        chk("exc_done", 32'(done), 1);
        chk("exc_taken", 32'(taken_cnt), 32'(exp_taken));
    endtask

    task automatic run_vec(input vec_t v, input logic pulse_valid);
        chk("idle_ready", 32'(ready), 1);
        opcode = v.op; funct = v.fn; zero = v.z; overflow = v.ov;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        opcode = 6'h3F; funct = 6'h3F;  // captured copy must be used
        chk("fetch_src", 32'(PCSource), 0);
        chk("fetch_wr", 32'(PCWrite), 1);
        chk("fetch_ready", 32'(ready), 0);
        tick();
        chk("decode_wr", 32'(PCWrite), 0);
        chk("decode_epc", 32'(EPCWrite), 0);
        if (v.exc == 1) begin
            tick();
            exp_cause = 1'b0;
            chk("dec_exc_epc", 32'(EPCWrite), 1);
            chk("dec_exc_cause", 32'(exc_cause), 0);
            chk("dec_exc_wr", 32'(PCWrite), 0);
            exc_tail();
        end else begin
            tick();
            if (pulse_valid) instr_valid = 1'b1;
            chk("resolve_src", 32'(PCSource), 32'(v.src));
            chk("resolve_wr", 32'(PCWrite), 32'(v.wr));
            chk("resolve_done", 32'(done), 0);
            if (v.exc == 2) begin
                tick();
                instr_valid = 1'b0;
                exp_cause = 1'b1;
                chk("ovf_epc", 32'(EPCWrite), 1);
                chk("ovf_cause", 32'(exc_cause), 1);
                exc_tail();
            end else begin
                if (v.wr && exp_taken != 16'hFFFF) exp_taken++;
                tick();
                instr_valid = 1'b0;
                chk("done_pulse", 32'(done), 1);
                chk("taken_cnt", 32'(taken_cnt), 32'(exp_taken));
            end
        end
        tick();
        chk("back_idle", 32'(ready), 1);
        chk("done_clear", 32'(done), 0);
        chk("cause_held", 32'(exc_cause), 32'(exp_cause));
    endtask

    // Accept an instruction and advance nt cycles without checking.
    task automatic launch(input logic [5:0] op, input logic [5:0] fn, input logic ov, input int nt);
        opcode = op; funct = fn; overflow = ov; zero = 1'b0;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        repeat (nt - 1) tick();
    endtask

    initial begin
        int cnt;
        vt[0]  = '{6'h04, 6'h00, 1'b1, 1'b0, 3'd1, 1'b1, 0};  // beq taken
        vt[1]  = '{6'h05, 6'h00, 1'b1, 1'b0, 3'd1, 1'b0, 0};  // bne not taken
        vt[2]  = '{6'h04, 6'h00, 1'b0, 1'b0, 3'd1, 1'b0, 0};  // beq not taken
        vt[3]  = '{6'h05, 6'h00, 1'b0, 1'b0, 3'd1, 1'b1, 0};  // bne taken
        vt[4]  = '{6'h02, 6'h00, 1'b0, 1'b0, 3'd3, 1'b1, 0};  // j
        vt[5]  = '{6'h03, 6'h00, 1'b0, 1'b0, 3'd3, 1'b1, 0};  // jal
        vt[6]  = '{6'h00, 6'h08, 1'b0, 1'b0, 3'd4, 1'b1, 0};  // jr
        vt[7]  = '{6'h00, 6'h20, 1'b0, 1'b0, 3'd0, 1'b0, 0};  // add, no ovf
        vt[8]  = '{6'h00, 6'h20, 1'b0, 1'b1, 3'd0, 1'b0, 2};  // add, ovf
        vt[9]  = '{6'h3F, 6'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1};  // invalid op
        vt[10] = '{6'h08, 6'h00, 1'b0, 1'b1, 3'd0, 1'b0, 2};  // addi, ovf
        vt[11] = '{6'h08, 6'h00, 1'b0, 1'b0, 3'd0, 1'b0, 0};  // addi, no ovf
        vt[12] = '{6'h23, 6'h00, 1'b0, 1'b1, 3'd0, 1'b0, 0};  // lw ignores ovf
        vt[13] = '{6'h01, 6'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1};  // invalid op
        vt[14] = '{6'h00, 6'h08, 1'b1, 1'b1, 3'd4, 1'b1, 0};  // jr ignores ovf

        reset = 1'b1; instr_valid = 1'b0; opcode = '0; funct = '0;
        zero = 1'b0; overflow = 1'b0; mem_ready = 1'b0;
        tick(); tick();
        chk("rst_ready", 32'(ready), 1);
        chk("rst_src", 32'(PCSource), 0);
        chk("rst_wr", 32'(PCWrite), 0);
        chk("rst_epc", 32'(EPCWrite), 0);
        chk("rst_cause", 32'(exc_cause), 0);
        chk("rst_rd", 32'(exc_mem_rd), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_taken", 32'(taken_cnt), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) run_vec(vt[i], 1'b0);

        // mem_ready on the last allowed EXC_RD cycle must beat the timeout
        launch(6'h00, 6'h20, 1'b1, 5);
        exp_cause = 1'b1;
        repeat (15) tick();
        chk("race_rd_req", 32'(exc_mem_rd), 1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("race_load_src", 32'(PCSource), 5);
        chk("race_load_wr", 32'(PCWrite), 1);
        chk("race_not_halt", 32'(halted), 0);
        tick();
        chk("race_done", 32'(done), 1);
        tick();

        // reset in the middle of an exception
        launch(6'h00, 6'h22, 1'b1, 6);
        chk("mid_rd_req", 32'(exc_mem_rd), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_cause = 1'b0; exp_taken = '0;
        chk("mid_rst_ready", 32'(ready), 1);
        chk("mid_rst_rd", 32'(exc_mem_rd), 0);
        chk("mid_rst_cause", 32'(exc_cause), 0);
        chk("mid_rst_taken", 32'(taken_cnt), 0);

        // vector read never completes -> 16 request cycles then HALT
        launch(6'h3F, 6'h00, 1'b0, 4);
        cnt = 0;
        for (int g = 0; g < 100 && exc_mem_rd; g++) begin
            cnt++;
            tick();
        end
        chk("tmo_cycles", 32'(cnt), 16);
        chk("tmo_halted", 32'(halted), 1);
        instr_valid = 1'b1;
        repeat (5) tick();
        instr_valid = 1'b0;
        chk("halt_sticky", 32'(halted), 1);
        chk("halt_ready", 32'(ready), 0);
        chk("halt_rd", 32'(exc_mem_rd), 0);
        chk("halt_wr", 32'(PCWrite), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("halt_rst_halted", 32'(halted), 0);
        chk("halt_rst_ready", 32'(ready), 1);

        // saturation: preload near the top, then two jumps with a stray
        // instr_valid during RESOLVE that must be ignored
        force dut.taken_cnt_q = 16'hFFFE;
        tick();
        release dut.taken_cnt_q;
        exp_taken = 16'hFFFE;
        chk("preload", 32'(taken_cnt), 32'hFFFE);
        run_vec(vt[4], 1'b1);
        chk("sat_top", 32'(taken_cnt), 32'hFFFF);
        run_vec(vt[4], 1'b1);
        chk("sat_hold", 32'(taken_cnt), 32'hFFFF);
        tick();
        chk("stray_ignored", 32'(ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
